// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch/decode/execute control FSM with timeout fault
module fetch_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] pc_in,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [15:0] pc_d,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        exec_done,
  input  logic        jump_req,
  input  logic [15:0] jump_target,
  input  logic        halt_req,
  input  logic        fault_clr,
  output logic        fault,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, HALT = 3'd4, FAULT = 3'd5} state_t;
  state_t cur, nxt;
  logic [7:0] timer;
  logic expired;
  assign expired = timer == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur   <= IDLE;
      timer <= '0;
      ir    <= '0;
    end else begin
      cur   <= nxt;
      timer <= (nxt != cur) ? '0 : (cur == FETCH || cur == EXEC) ? timer + 8'd1 : '0;
      if (cur == FETCH && mem_ack) ir <= mem_data;
    end
  end
  // an ack or done arriving in the last allowed cycle beats the timeout
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = run ? FETCH : IDLE;
      FETCH:   nxt = mem_ack ? DECODE : expired ? FAULT : FETCH;
      DECODE:  nxt = EXEC;
      EXEC:    nxt = exec_done ? (halt_req ? HALT : FETCH) : expired ? FAULT : EXEC;
      HALT:    nxt = run ? HALT : IDLE;
      FAULT:   nxt = fault_clr ? IDLE : FAULT;
      default: nxt = IDLE;
    endcase
  end
  assign mem_req  = cur == FETCH;
  assign mem_addr = mem_req ? pc_in : '0;
  assign pc_inc   = mem_req && mem_ack;
  assign pc_load  = cur == EXEC && exec_done && !halt_req && jump_req;
  assign pc_d     = pc_load ? jump_target : '0;
  assign ir_valid = cur == DECODE;
  assign fault    = cur == FAULT;
  assign state    = cur;
endmodule
